// File: rtl/alu_issue_sched.sv
// alu_issue_sched: issue scheduler for the 4-thread / 2-ALU core.
// Each cycle it picks up to two eligible threads round-robin and steers them onto ALU0/ALU1.
// An ALU whose current instruction raises hold keeps its thread, and that ALU takes no new grant.
// A taken jump squashes the thread's IF/ID. The thread then stays ineligible for FLUSH_CYC cycles.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req[3:0]                 per-thread decoded instruction ready, held until ack
//   hold_alu0/1              ALU hold request, meaningful only while that ALU is valid
//   jump_alu0/1              ALU taken-jump, meaningful only while that ALU is valid
//   alu0_vld/tid, alu1_*     registered grant per ALU
//   thread_ack[3:0]          one-hot per active grant (thread is in EX this cycle)
//   thread_flush[3:0]        1-cycle pulse after a taken jump of that thread
module alu_issue_sched #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned FLUSH_CYC   = 2,
  parameter int unsigned CNT_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] req,
  input  logic                   hold_alu0,
  input  logic                   hold_alu1,
  input  logic                   jump_alu0,
  input  logic                   jump_alu1,
  output logic                   alu0_vld,
  output logic [1:0]             alu0_tid,
  output logic                   alu1_vld,
  output logic [1:0]             alu1_tid,
  output logic [NUM_THREADS-1:0] thread_ack,
  output logic [NUM_THREADS-1:0] thread_flush
);

  logic                   alu0_vld_q, alu0_vld_d, alu1_vld_q, alu1_vld_d;
  logic [1:0]             alu0_tid_q, alu0_tid_d, alu1_tid_q, alu1_tid_d;
  logic [1:0]             rr_q, rr_d;
  logic [NUM_THREADS-1:0] flush_q, flush_d;
  logic [CNT_W-1:0]       cnt_q [NUM_THREADS];
  logic [CNT_W-1:0]       cnt_d [NUM_THREADS];

  logic                   lock0, lock1, jmp0, jmp1;
  logic [NUM_THREADS-1:0] elig;
  logic                   free0, free1, any_grant;
  logic [1:0]             idx, last_tid;

  assign alu0_vld     = alu0_vld_q;
  assign alu0_tid     = alu0_tid_q;
  assign alu1_vld     = alu1_vld_q;
  assign alu1_tid     = alu1_tid_q;
  assign thread_flush = flush_q;

  // Hold/jump are only meaningful for a valid ALU; hold wins over jump.
  assign lock0 = alu0_vld_q & hold_alu0;
  assign lock1 = alu1_vld_q & hold_alu1;
  assign jmp0  = alu0_vld_q & jump_alu0 & ~hold_alu0;
  assign jmp1  = alu1_vld_q & jump_alu1 & ~hold_alu1;

  always_comb begin
    thread_ack = '0;
    if (alu0_vld_q) thread_ack[alu0_tid_q] = 1'b1;
    if (alu1_vld_q) thread_ack[alu1_tid_q] = 1'b1;
  end

  // A thread in EX is never re-granted on the next cycle; locked threads stay via the lock path.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      elig[i] = req[i] & (cnt_q[i] == '0) & ~thread_ack[i];
    end
  end

  always_comb begin
    alu0_vld_d = lock0;
    alu0_tid_d = lock0 ? alu0_tid_q : 2'd0;
    alu1_vld_d = lock1;
    alu1_tid_d = lock1 ? alu1_tid_q : 2'd0;
    free0      = ~lock0;
    free1      = ~lock1;
    any_grant  = 1'b0;
    last_tid   = 2'd0;
    idx        = 2'd0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      idx = rr_q + 2'(k);
      if (elig[idx]) begin
        if (free0) begin
          alu0_vld_d = 1'b1;
          alu0_tid_d = idx;
          free0      = 1'b0;
          any_grant  = 1'b1;
          last_tid   = idx;
        end else if (free1) begin
          alu1_vld_d = 1'b1;
          alu1_tid_d = idx;
          free1      = 1'b0;
          any_grant  = 1'b1;
          last_tid   = idx;
        end
      end
    end
    // Locks never move the pointer; only new grants do.
    rr_d = any_grant ? last_tid + 2'd1 : rr_q;
  end

  always_comb begin
    flush_d = '0;
    if (jmp0) flush_d[alu0_tid_q] = 1'b1;
    if (jmp1) flush_d[alu1_tid_q] = 1'b1;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (flush_d[i]) begin
        cnt_d[i] = CNT_W'(FLUSH_CYC);
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu0_vld_q <= 1'b0;
      alu0_tid_q <= 2'd0;
      alu1_vld_q <= 1'b0;
      alu1_tid_q <= 2'd0;
      rr_q       <= 2'd0;
      flush_q    <= '0;
      for (int i = 0; i < NUM_THREADS; i++) cnt_q[i] <= '0;
    end else begin
      alu0_vld_q <= alu0_vld_d;
      alu0_tid_q <= alu0_tid_d;
      alu1_vld_q <= alu1_vld_d;
      alu1_tid_q <= alu1_tid_d;
      rr_q       <= rr_d;
      flush_q    <= flush_d;
      for (int i = 0; i < NUM_THREADS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
